// File: rtl/memifdef.sv
// Shared definitions for the data-memory responder: FSM states,
// legal byte-enable patterns and default parameter values.
package memifdef;

    localparam int DEPTH_WORDS_DEF = 1024;
    localparam int LATENCY_DEF     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    // True when the byte-enable pattern matches the address offset
    function automatic logic be_aligned(
        input logic [3:0] be,
        input logic [1:0] off
    );
        logic ok;
        ok = 1'b0;
        case ({be, off})
            {BE_B0, 2'd0}: ok = 1'b1;
            {BE_B1, 2'd1}: ok = 1'b1;
            {BE_B2, 2'd2}: ok = 1'b1;
            {BE_B3, 2'd3}: ok = 1'b1;
            {BE_H0, 2'd0}: ok = 1'b1;
            {BE_H1, 2'd2}: ok = 1'b1;
            {BE_W,  2'd0}: ok = 1'b1;
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables.
// Synchronous write, combinational read, contents survive reset.
module dmem_array
    import memifdef::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int AW          = 10
) (
    input  logic          i_clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic        w_in_range;

    assign w_in_range = 32'(i_idx) < 32'(DEPTH_WORDS);
    assign o_rdata    = w_in_range ? r_mem[i_idx] : 32'h0;

    // Commit enabled byte lanes of the addressed word
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with valid/ready handshakes.
// Optional alignment checking: define DMEM_MISALIGN_CHECK_EN.
module dmem_responder
    import memifdef::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int LATENCY     = LATENCY_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic          w_idle;
    logic          w_accept;
    logic          w_go_resp;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_be;
    logic          w_oor;
    logic          w_mis;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_wbe;
    logic [31:0]   w_rdata;
    logic [31:0]   w_rsp_rdata;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle & req_valid_i;

    // With LATENCY==1 the access happens on the acceptance edge itself,
    // so the live request fields bypass the holding registers.
    assign w_go_resp = ((r_state == ST_WAIT) && (r_cnt == 4'd0))
                     || (w_accept && (LATENCY == 1));

    assign w_we    = w_idle ? req_we_i    : r_we;
    assign w_addr  = w_idle ? req_addr_i  : r_addr;
    assign w_wdata = w_idle ? req_wdata_i : r_wdata;
    assign w_be    = w_idle ? req_be_i    : r_be;

    assign w_oor = {2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_mis = ~be_aligned(w_be, w_addr[1:0]);
`else
    logic w_unused_off;
    assign w_unused_off = ^w_addr[1:0];
    assign w_mis        = 1'b0;
`endif

    assign w_err       = w_oor | w_mis;
    assign w_idx       = w_addr[AW+1:2];
    assign w_wbe       = (w_go_resp && w_we && !w_err) ? w_be : 4'b0000;
    assign w_rsp_rdata = (w_err || w_we) ? 32'h0 : w_rdata;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .i_clk   (clk_i),
        .i_we    (w_wbe),
        .i_idx   (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // Request/response FSM with latency counter and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_be        <= 4'b0000;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_we        <= req_we_i;
                        r_addr      <= req_addr_i;
                        r_wdata     <= req_wdata_i;
                        r_be        <= req_be_i;
                        r_req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_err;
                            r_rsp_rdata <= w_rsp_rdata;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= w_rsp_rdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= 32'h0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= 4'd0;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'h0;
                end
            endcase
        end
    end

    assign req_ready_o = r_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_rdata_o = r_rsp_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed cases plus random
// traffic against a word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int NW    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic [3:0]  req_be_i = 4'h0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mm [NW];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic bit legal(input logic [3:0] be, input logic [1:0] off);
`ifdef DMEM_MISALIGN_CHECK_EN
        return (be == 4'b0001 && off == 2'd0) || (be == 4'b0010 && off == 2'd1)
            || (be == 4'b0100 && off == 2'd2) || (be == 4'b1000 && off == 2'd3)
            || (be == 4'b0011 && off == 2'd0) || (be == 4'b1100 && off == 2'd2)
            || (be == 4'b1111 && off == 2'd0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic exp_t model(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        int   idx;
        idx     = int'(addr[31:2]);
        e.err   = (idx >= DEPTH) || !legal(be, addr[1:0]);
        e.rdata = 32'h0;
        e.acc   = 0;
        if (!e.err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mm[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                e.rdata = mm[idx];
            end
        end
        return e;
    endfunction

    // Monitor: pop on each new response, check hold stability in RESP
    exp_t        me;
    logic        pv = 1'b0;
    logic [31:0] prd = 32'h0;
    logic        perr = 1'b0;
    always @(negedge clk) begin
        if (rst_n && rsp_valid_o) begin
            if (!pv) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_rsp: got valid expected none");
                end else begin
                    me = q.pop_front();
                    chk("rdata", rsp_rdata_o, me.rdata);
                    chk("err", 32'(rsp_err_o), 32'(me.err));
                    chk("latency", 32'(cyc - me.acc), 32'(LAT));
                end
            end else begin
                chk("hold_rdata", rsp_rdata_o, prd);
                chk("hold_err", 32'(rsp_err_o), 32'(perr));
                chk("ready_in_resp", 32'(req_ready_o), 32'd0);
            end
        end
        pv   = rst_n & rsp_valid_o;
        prd  = rsp_rdata_o;
        perr = rsp_err_o;
    end

    task automatic xact(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int hold);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (!req_ready_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            checks++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
            return;
        end
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_be_i    = be;
        @(posedge clk);
        #1;
        e     = model(we, addr, wdata, be);
        e.acc = cyc;
        q.push_back(e);
        req_valid_i = 1'($urandom_range(0, 1));
        req_addr_i  = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid_o && n < 40);
        if (!rsp_valid_o) begin
            checks++;
            $display("FAIL rsp_timeout: got 0 expected 1");
            if (q.size() > 0) void'(q.pop_front());
        end
        for (int h = 0; h < hold; h++) begin
            rsp_ready_i = 1'b0;
            req_valid_i = 1'b1;
            req_we_i    = 1'($urandom_range(0, 1));
            req_addr_i  = $urandom_range(0, 63);
            @(negedge clk);
        end
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b0;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        chk("idle_ready", 32'(req_ready_o), 32'd1);
        chk("valid_drop", 32'(rsp_valid_o), 32'd0);
    endtask

    task automatic reset_mid_wait();
        @(negedge clk);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 32'h20;
        req_wdata_i = 32'hFFFF_FFFF;
        req_be_i    = 4'hF;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_err", 32'(rsp_err_o), 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'h0);
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(req_ready_o), 32'd1);
        chk("reset_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset_err", 32'(rsp_err_o), 32'd0);
        chk("reset_rdata", rsp_rdata_o, 32'h0);
        rst_n = 1'b1;

        for (int w = 0; w < NW; w++)
            xact(1'b1, 32'(w * 4), $urandom, 4'hF, 0);

        xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        xact(1'b0, 32'h10, 32'h0, 4'hF, 0);
        xact(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0);
        xact(1'b0, 32'h10, 32'h0, 4'hF, 0);
        xact(1'b1, 32'h12, 32'h1234_0000, 4'b1100, 0);
        xact(1'b0, 32'h10, 32'h0, 4'hF, 0);

        xact(1'b0, 32'h1000, 32'h0, 4'hF, 0);
        xact(1'b1, 32'h1000, 32'h5555_5555, 4'hF, 0);
        xact(1'b0, 32'h0, 32'h0, 4'hF, 0);
        xact(1'b1, 32'h0, 32'h0, 4'h0, 0);
        xact(1'b0, 32'h0, 32'h0, 4'hF, 0);

        xact(1'b0, 32'h10, 32'h0, 4'hF, 5);

        reset_mid_wait();
        xact(1'b0, 32'h20, 32'h0, 4'hF, 0);

        xact(1'b1, 32'h21, 32'hFFFF_FFFF, 4'hF, 0);
        xact(1'b0, 32'h20, 32'h0, 4'hF, 0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0)
                a = {$urandom_range(1024, 32'h3FFF_FFFF), 2'b00} | 32'($urandom_range(0, 3));
            else
                a = 32'($urandom_range(0, NW - 1) * 4 + $urandom_range(0, 3));
            xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3));
        end

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to rsp_valid_o (legal range 1..15).
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  1  initiator presents request.
REQ-006 SHALL have port req_ready_o  output  1  responder can accept request.
REQ-007 SHALL have port req_we_i  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr_i  input  32  byte address.
REQ-009 SHALL have port req_wdata_i  input  32  store data, already lane-aligned.
REQ-010 SHALL have port req_be_i  input  4  byte enables, bit n = byte lane n.
REQ-011 SHALL have port rsp_valid_o  output  1  response available.
REQ-012 SHALL have port rsp_ready_i  input  1  initiator consumes response.
REQ-013 SHALL have port rsp_rdata_o  output  32  full load word (lane extraction/sign extension done by initiator).
REQ-014 SHALL have port rsp_err_o  output  1  request failed, qualified by rsp_valid_o.

Function
REQ-015 SHALL implement FSM IDLE, WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-016 Handshake: request accepted on edge where req_valid_i & req_ready_o; addr/we/wdata/be captured into holding registers that edge.
REQ-017 IDLE -> WAIT on acceptance with down-counter loaded LATENCY-1; if LATENCY==1, IDLE -> RESP directly.
REQ-018 WAIT decrements each cycle; counter 0 -> RESP next edge; rsp_valid_o asserts exactly LATENCY cycles after acceptance edge.
REQ-019 Memory access (read sample and write commit) SHALL occur on the edge entering RESP, never earlier.
REQ-020 Store: only lanes with be=1 updated; other lanes unchanged; rsp_rdata_o = 0 for stores.
REQ-021 Load: rsp_rdata_o = word at index addr[31:2] as of the access edge.
REQ-022 Word index = addr[31:2]; index >= DEPTH_WORDS -> rsp_err_o=1, no write, rsp_rdata_o=0.
REQ-023 RESP holds rsp_valid_o, rsp_rdata_o, rsp_err_o stable until rsp_ready_i=1; then -> IDLE next edge.
REQ-024 No back-to-back overlap: new request only accepted in IDLE, so max throughput one transaction per LATENCY+2 cycles.
REQ-025 req_valid_i deasserted mid-WAIT SHALL NOT cancel the transaction.
REQ-026 be==0 store SHALL be a no-op completing with rsp_err_o=0 (unless REQ-031 flags it).

Reset
REQ-027 rst_ni low SHALL immediately force IDLE, counter 0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, req_ready_o=1 after release.
REQ-028 Reset mid-WAIT SHALL abort transaction; a pending store SHALL NOT commit.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro DMEM_MISALIGN_CHECK_EN SHALL gate alignment checking.
REQ-031 Defined: legal (be, addr[1:0]) pairs only 0001/00, 0010/01, 0100/10, 1000/11, 0011/00, 1100/10, 1111/00; any other pair -> rsp_err_o=1, no write, rdata 0, same latency.
REQ-032 Undefined: addr[1:0] ignored, any be accepted, rsp_err_o only from REQ-022.

Structure
REQ-033 FSM state encodings, legal BE pattern constants and default parameter values SHALL live in shared header memifdef.
REQ-034 Storage SHALL be sub-module dmem_array (DEPTH_WORDS x 32, per-byte write enable, synchronous write, combinational read); dmem_responder owns FSM, counter, checks.

Verification
REQ-035 Store 0xDEADBEEF be=1111 addr 0x10, then load 0x10 -> rsp_rdata_o=0xDEADBEEF, err=0, rsp_valid_o exactly 2 cycles after each acceptance (LATENCY=2).
REQ-036 After REQ-035, store 0x000000AA be=0001 addr 0x10, load 0x10 -> 0xDEADBEAA; store 0x12340000 be=1100 addr 0x12 -> load 0x1234BEAA.
REQ-037 Load addr 0x1000 with DEPTH_WORDS=1024 -> rsp_err_o=1, rdata 0; store there -> err=1, word 0 unchanged.
REQ-038 rsp_ready_i held 0 for 5 cycles in RESP -> rsp_valid_o/rdata stable 5 cycles, req_ready_o=0, req_valid_i ignored; ready=1 -> IDLE next edge.
REQ-039 Store 0xFFFFFFFF addr 0x20, rst_ni pulsed low during WAIT -> outputs reset instantly; later load 0x20 returns prior contents (not 0xFFFFFFFF).
REQ-040 With DMEM_MISALIGN_CHECK_EN: store be=1111 addr 0x21 -> err=1, no write; without macro: same stimulus writes word 0x20, err=0.
